// File: rtl/ex_pipe_alu_pkg.sv
// ex_pipe_alu_pkg: shared opcode, result-class and divider-state encodings for the EX stage.
package ex_pipe_alu_pkg;
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} div_state_t;
endpackage

// File: rtl/ex_pipe_alu_div_iter.sv
// div_iter: radix-2 restoring divider, one quotient bit per cycle, signed fix-up on the way out.
module div_iter
    import ex_pipe_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic              i_annul,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);
    localparam int M     = DATA_W - 1;
    localparam int CNT_W = $clog2(DATA_W);
    div_state_t r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_quo, r_rem, r_dsr, w_dvd_mag, w_dsr_mag, w_rem_nx;
    logic [DATA_W:0] w_trial;
    logic r_neg_q, r_neg_r, w_fits;
    always_comb begin
        w_next = i_annul ? IDLE :
                 r_state == IDLE ? (i_start ? DIV_RUN : IDLE) :
                 r_state == DIV_RUN ? (r_cnt == CNT_W'(DATA_W - 1) ? DIV_DONE : DIV_RUN) : IDLE;
        w_dvd_mag = (i_signed && i_dividend[M]) ? -i_dividend : i_dividend;
        w_dsr_mag = (i_signed && i_divisor[M]) ? -i_divisor : i_divisor;
        w_trial = {r_rem, r_quo[M]};
        w_fits = w_trial >= {1'b0, r_dsr};
        w_rem_nx = w_fits ? DATA_W'(w_trial - {1'b0, r_dsr}) : w_trial[DATA_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_quo <= w_dvd_mag;
                r_rem <= '0;
                r_dsr <= w_dsr_mag;
                r_cnt <= '0;
                r_neg_q <= i_signed && (i_dividend[M] ^ i_divisor[M]);
                r_neg_r <= i_signed && i_dividend[M];
            end else if (r_state == DIV_RUN) begin
                r_quo <= {r_quo[M-1:0], w_fits};
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_busy = (r_state == IDLE && i_start) || r_state == DIV_RUN;
    assign o_done = r_state == DIV_DONE;
    assign o_quotient = r_neg_q ? -r_quo : r_quo;
    assign o_remainder = r_neg_r ? -r_rem : r_rem;
endmodule

// File: rtl/ex_pipe_alu.sv
// ex_pipe_alu: EX stage ALU with registered result, HI/LO, multiplier and iterative divider.
module ex_pipe_alu
    import ex_pipe_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W),
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              annul_i,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ov_o,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int M = DATA_W - 1;
    logic [DATA_W-1:0] r_hi, r_lo, w_sra, w_sum, w_diff, w_logic, w_shift, w_arith, w_move, w_result;
    logic [DATA_W-1:0] w_quo, w_rem;
    logic [2*DATA_W-1:0] w_prod;
    logic [SHAMT_W-1:0] w_shamt;
    logic w_ov, w_is_div, w_div_zero, w_start, w_busy, w_done, w_bubble, w_smul;
    assign w_shamt = reg1_i[SHAMT_W-1:0];
    assign w_sra = $signed(reg2_i) >>> w_shamt;
    always_comb begin
        w_sum = reg1_i + reg2_i;
        w_diff = reg1_i - reg2_i;
        w_logic = aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                  aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                  aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) :
                  aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i : '0;
        w_shift = aluop_i == EXE_SLL_OP ? reg2_i << w_shamt :
                  aluop_i == EXE_SRL_OP ? reg2_i >> w_shamt :
                  aluop_i == EXE_SRA_OP ? w_sra : '0;
        w_arith = (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDU_OP) ? w_sum :
                  (aluop_i == EXE_SUB_OP || aluop_i == EXE_SUBU_OP) ? w_diff :
                  aluop_i == EXE_SLT_OP  ? {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)} :
                  aluop_i == EXE_SLTU_OP ? {{(DATA_W-1){1'b0}}, reg1_i < reg2_i} : '0;
        w_ov = (aluop_i == EXE_ADD_OP && reg1_i[M] == reg2_i[M] && w_sum[M] != reg1_i[M]) ||
               (aluop_i == EXE_SUB_OP && reg1_i[M] != reg2_i[M] && w_diff[M] != reg1_i[M]);
        // A divide finishing this cycle is visible to MFHI/MFLO before it lands in HI/LO
        w_move = aluop_i == EXE_MFHI_OP ? (w_done ? w_rem : r_hi) :
                 aluop_i == EXE_MFLO_OP ? (w_done ? w_quo : r_lo) : '0;
        w_result = alusel_i == EXE_RES_LOGIC ? w_logic :
                   alusel_i == EXE_RES_SHIFT ? w_shift :
                   alusel_i == EXE_RES_ARITH ? w_arith :
                   alusel_i == EXE_RES_MOVE  ? w_move : '0;
        w_smul = aluop_i == EXE_MULT_OP;
        w_prod = {{DATA_W{w_smul & reg1_i[M]}}, reg1_i} * {{DATA_W{w_smul & reg2_i[M]}}, reg2_i};
        w_is_div = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
        w_div_zero = reg2_i == '0;
        w_start = valid_i && w_is_div && !w_div_zero;
        w_bubble = !valid_i || annul_i || w_busy;
    end
    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk(clk),
        .rst(rst),
        .i_start(w_start),
        .i_signed(aluop_i == EXE_DIV_OP),
        .i_annul(annul_i),
        .i_dividend(reg1_i),
        .i_divisor(reg2_i),
        .o_busy(w_busy),
        .o_done(w_done),
        .o_quotient(w_quo),
        .o_remainder(w_rem)
    );
    assign stallreq_o = !rst && w_busy;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            wd_o <= '0;
            wreg_o <= 1'b0;
            wdata_o <= '0;
            ov_o <= 1'b0;
        end else begin
            valid_o <= !w_bubble;
            wd_o <= w_bubble ? '0 : wd_i;
            wreg_o <= !w_bubble && wreg_i && !w_ov;
            wdata_o <= w_bubble ? '0 : w_result;
            ov_o <= !w_bubble && w_ov;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!annul_i) begin
            if (w_done) begin
                r_hi <= w_rem;
                r_lo <= w_quo;
            end else if (valid_i && !w_busy) begin
                if (aluop_i == EXE_MTHI_OP) r_hi <= reg1_i;
                if (aluop_i == EXE_MTLO_OP) r_lo <= reg1_i;
                if (aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP) {r_hi, r_lo} <= w_prod;
                if (w_is_div && w_div_zero) begin
                    r_hi <= reg1_i;
                    r_lo <= '1;
                end
            end
        end
    end
    assign hi_o = r_hi;
    assign lo_o = r_lo;
endmodule

// File: tb/tb_ex_pipe_alu.sv
// tb_ex_pipe_alu: directed vector table, randomized ops against a behavioural model, divider corner sequences.
module tb_ex_pipe_alu;
    import ex_pipe_alu_pkg::*;
    localparam int W = 32;
    logic clk = 1'b0, rst, valid_i, annul_i, wreg_i;
    logic [7:0] aluop_i;
    logic [2:0] alusel_i;
    logic [W-1:0] reg1_i, reg2_i;
    logic [4:0] wd_i;
    logic valid_o, wreg_o, ov_o, stallreq_o;
    logic [4:0] wd_o;
    logic [W-1:0] wdata_o, hi_o, lo_o;
    logic [W-1:0] m_hi, m_lo;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] op;
        logic [2:0] sel;
        logic [W-1:0] a, b, res;
        logic wreg, ov;
    } vec_t;
    typedef struct {
        logic [7:0] op;
        logic [2:0] sel;
    } opsel_t;
    vec_t tv[$];
    opsel_t ops[$];

    ex_pipe_alu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .annul_i(annul_i), .aluop_i(aluop_i),
        .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .ov_o(ov_o),
        .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic v, input logic wr);
        aluop_i = op;
        alusel_i = sel;
        reg1_i = a;
        reg2_i = b;
        valid_i = v;
        wreg_i = wr;
        wd_i = 5'($urandom);
    endtask

    // Reference: results from full-precision integer arithmetic, HI/LO as plain state
    task automatic ref_op(input logic [7:0] op, input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] res, output logic ov);
        longint sa, sb, ua, ub, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        ov = 1'b0;
        t = 0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP) res = a | b;
            else if (op == EXE_AND_OP) res = a & b;
            else if (op == EXE_NOR_OP) res = ~(a | b);
            else if (op == EXE_XOR_OP) res = a ^ b;
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) res = 32'(ub * (64'd1 << a[4:0]));
            else if (op == EXE_SRL_OP) res = 32'(ub / (64'd1 << a[4:0]));
            else if (op == EXE_SRA_OP) res = 32'(sb >>> a[4:0]);
        end else if (sel == EXE_RES_ARITH) begin
            if (op == EXE_ADD_OP || op == EXE_ADDU_OP) t = sa + sb;
            if (op == EXE_SUB_OP || op == EXE_SUBU_OP) t = sa - sb;
            res = t[31:0];
            if (op == EXE_ADD_OP || op == EXE_SUB_OP) ov = t > 64'sd2147483647 || t < -64'sd2147483648;
            if (op == EXE_SLT_OP) res = {31'b0, sa < sb};
            if (op == EXE_SLTU_OP) res = {31'b0, ua < ub};
        end else if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP) res = m_hi;
            if (op == EXE_MFLO_OP) res = m_lo;
        end
        if (op == EXE_MTHI_OP) m_hi = a;
        if (op == EXE_MTLO_OP) m_lo = a;
        if (op == EXE_MULT_OP) begin t = sa * sb; {m_hi, m_lo} = t; end
        if (op == EXE_MULTU_OP) begin t = ua * ub; {m_hi, m_lo} = t; end
        if ((op == EXE_DIV_OP || op == EXE_DIVU_OP) && b == 0) begin m_lo = '1; m_hi = a; end
    endtask

    task automatic do_div(input string name, input logic [7:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r, input int n_exp);
        int n;
        valid_i = 1'b0;
        tick;
        drive(op, EXE_RES_NOP, a, b, 1'b1, 1'b0);
        #1;
        n = 0;
        while (stallreq_o && n < 100) begin
            tick;
            n++;
        end
        chk({name, "_stall_cycles"}, 64'(n), 64'(n_exp));
        chk({name, "_bubble"}, {valid_o, wreg_o, wdata_o}, 0);
        tick;
        chk({name, "_lo"}, lo_o, q);
        chk({name, "_hi"}, hi_o, r);
        chk({name, "_valid"}, valid_o, 1);
        valid_i = 1'b0;
        m_lo = q;
        m_hi = r;
    endtask

    initial begin
        logic [W-1:0] res, a, b;
        logic ov, v;
        int k;
        rst = 1'b1;
        annul_i = 1'b0;
        drive(EXE_NOP_OP, EXE_RES_NOP, 0, 0, 1'b0, 1'b0);
        tick;
        tick;
        chk("rst_stall", stallreq_o, 0);
        tick;
        chk("rst_outs", {valid_o, wreg_o, ov_o, wd_o, wdata_o}, 0);
        chk("rst_hilo", {hi_o, lo_o}, 0);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;

        tv.push_back('{EXE_SRA_OP,   EXE_RES_SHIFT, 32'd4,        32'h80000010, 32'hF8000001, 1'b1, 1'b0});
        tv.push_back('{EXE_ADD_OP,   EXE_RES_ARITH, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1});
        tv.push_back('{EXE_ADDU_OP,  EXE_RES_ARITH, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1, 1'b0});
        tv.push_back('{EXE_ADD_OP,   EXE_RES_ARITH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0});
        tv.push_back('{EXE_SUB_OP,   EXE_RES_ARITH, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1});
        tv.push_back('{EXE_SUBU_OP,  EXE_RES_ARITH, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b0});
        tv.push_back('{EXE_SLT_OP,   EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0});
        tv.push_back('{EXE_SLTU_OP,  EXE_RES_ARITH, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
        tv.push_back('{EXE_OR_OP,    EXE_RES_LOGIC, 32'hF0F00000, 32'h0000FF0F, 32'hF0F0FF0F, 1'b1, 1'b0});
        tv.push_back('{EXE_AND_OP,   EXE_RES_LOGIC, 32'hF0F0FFFF, 32'h0FF0F0F0, 32'h00F0F0F0, 1'b1, 1'b0});
        tv.push_back('{EXE_NOR_OP,   EXE_RES_LOGIC, 32'h00000000, 32'h0F0F0000, 32'hF0F0FFFF, 1'b1, 1'b0});
        tv.push_back('{EXE_XOR_OP,   EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b1, 1'b0});
        tv.push_back('{8'hFF,        EXE_RES_LOGIC, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0});
        tv.push_back('{EXE_SLL_OP,   EXE_RES_SHIFT, 32'd8,        32'd1,        32'h00000100, 1'b1, 1'b0});
        tv.push_back('{EXE_SRL_OP,   EXE_RES_SHIFT, 32'd4,        32'h80000010, 32'h08000001, 1'b1, 1'b0});
        tv.push_back('{EXE_MULT_OP,  EXE_RES_NOP,   32'hFFFFFFFF, 32'd2,        32'h00000000, 1'b1, 1'b0});
        tv.push_back('{EXE_MFHI_OP,  EXE_RES_MOVE,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1'b0});
        tv.push_back('{EXE_MFLO_OP,  EXE_RES_MOVE,  32'h0,        32'h0,        32'hFFFFFFFE, 1'b1, 1'b0});
        tv.push_back('{EXE_MULTU_OP, EXE_RES_NOP,   32'hFFFFFFFF, 32'd2,        32'h00000000, 1'b1, 1'b0});
        tv.push_back('{EXE_MFHI_OP,  EXE_RES_MOVE,  32'h0,        32'h0,        32'h00000001, 1'b1, 1'b0});
        tv.push_back('{EXE_MTLO_OP,  EXE_RES_NOP,   32'hCAFEBABE, 32'h0,        32'h00000000, 1'b1, 1'b0});
        tv.push_back('{EXE_MFLO_OP,  EXE_RES_MOVE,  32'h0,        32'h0,        32'hCAFEBABE, 1'b1, 1'b0});
        foreach (tv[i]) begin
            drive(tv[i].op, tv[i].sel, tv[i].a, tv[i].b, 1'b1, 1'b1);
            tick;
            chk($sformatf("vec%0d_data", i), wdata_o, tv[i].res);
            chk($sformatf("vec%0d_wreg", i), wreg_o, tv[i].wreg);
            chk($sformatf("vec%0d_ov", i), ov_o, tv[i].ov);
            chk($sformatf("vec%0d_valid", i), {valid_o, wd_o}, {1'b1, wd_i});
        end
        m_hi = 32'h1;
        m_lo = 32'hCAFEBABE;

        ops = '{'{EXE_OR_OP, EXE_RES_LOGIC}, '{EXE_AND_OP, EXE_RES_LOGIC}, '{EXE_NOR_OP, EXE_RES_LOGIC},
                '{EXE_XOR_OP, EXE_RES_LOGIC}, '{EXE_SLL_OP, EXE_RES_SHIFT}, '{EXE_SRL_OP, EXE_RES_SHIFT},
                '{EXE_SRA_OP, EXE_RES_SHIFT}, '{EXE_ADD_OP, EXE_RES_ARITH}, '{EXE_ADDU_OP, EXE_RES_ARITH},
                '{EXE_SUB_OP, EXE_RES_ARITH}, '{EXE_SUBU_OP, EXE_RES_ARITH}, '{EXE_SLT_OP, EXE_RES_ARITH},
                '{EXE_SLTU_OP, EXE_RES_ARITH}, '{EXE_MFHI_OP, EXE_RES_MOVE}, '{EXE_MFLO_OP, EXE_RES_MOVE},
                '{EXE_MTHI_OP, EXE_RES_NOP}, '{EXE_MTLO_OP, EXE_RES_NOP}, '{EXE_MULT_OP, EXE_RES_NOP},
                '{EXE_MULTU_OP, EXE_RES_NOP}, '{EXE_DIV_OP, EXE_RES_NOP}, '{EXE_DIVU_OP, EXE_RES_NOP}};
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, ops.size() - 1);
            a = $urandom;
            b = (ops[k].op == EXE_DIV_OP || ops[k].op == EXE_DIVU_OP) ? 32'd0 : $urandom;
            v = $urandom_range(0, 9) != 0;
            drive(ops[k].op, ops[k].sel, a, b, v, 1'(($urandom)));
            res = '0;
            ov = 1'b0;
            if (v) ref_op(ops[k].op, ops[k].sel, a, b, res, ov);
            tick;
            chk($sformatf("rnd%0d_valid", i), valid_o, v);
            chk($sformatf("rnd%0d_data", i), wdata_o, res);
            chk($sformatf("rnd%0d_wreg", i), wreg_o, v && wreg_i && !ov);
            chk($sformatf("rnd%0d_ov", i), ov_o, ov);
            chk($sformatf("rnd%0d_hi", i), hi_o, m_hi);
            chk($sformatf("rnd%0d_lo", i), lo_o, m_lo);
        end

        do_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        do_div("div_min_m1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33);
        do_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        do_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33);
        do_div("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0);

        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 1'b1, 1'b0);
        repeat (10) tick;
        chk("annul_pre_stall", stallreq_o, 1);
        annul_i = 1'b1;
        tick;
        annul_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("annul_stall", stallreq_o, 0);
        chk("annul_bubble", {valid_o, wreg_o, wdata_o}, 0);
        repeat (40) tick;
        chk("annul_hilo", {hi_o, lo_o}, {m_hi, m_lo});
        do_div("div_after_annul", EXE_DIVU_OP, 32'd9, 32'd4, 32'd2, 32'd1, 33);

        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd50, 32'd5, 1'b1, 1'b0);
        repeat (5) tick;
        rst = 1'b1;
        #1;
        chk("rstdiv_stall", stallreq_o, 0);
        tick;
        chk("rstdiv_outs", {valid_o, wreg_o, ov_o, wd_o, wdata_o, hi_o, lo_o}, 0);
        rst = 1'b0;
        valid_i = 1'b0;
        repeat (40) tick;
        chk("rstdiv_no_late_write", {hi_o, lo_o, stallreq_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_pipe_alu.md
EX_PIPE_ALU -- requirements
Module: ex_pipe_alu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width (power of 2, 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(DATA_W), meaning shift-amount width.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning destination register address width.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- valid_i  in  1  operation present.
- annul_i  in  1  flush; cancels the current op and any division in flight.
- aluop_i  in  8  operation code (EXE_*_OP).
- alusel_i  in  3  result class (EXE_RES_*).
- reg1_i  in  DATA_W  operand 1; shift amount in [SHAMT_W-1:0].
- reg2_i  in  DATA_W  operand 2.
- wd_i  in  ADDR_W  destination register.
- wreg_i  in  1  write-enable request.
- valid_o  out  1  registered result valid.
- wd_o  out  ADDR_W  registered destination.
- wreg_o  out  1  registered write enable.
- wdata_o  out  DATA_W  registered result.
- ov_o  out  1  one-cycle signed-overflow flag.
- stallreq_o  out  1  combinational pipeline stall request.
- hi_o  out  DATA_W  HI register.
- lo_o  out  DATA_W  LO register.

Function
REQ-005 SHALL register every result: one-cycle latency from valid_i to valid_o for all non-divide ops.
REQ-006 SHALL implement the LOGIC class: OR, AND, NOR, XOR; unknown aluop yields 0.
REQ-007 SHALL implement the SHIFT class: SLL, SRL, SRA on reg2_i by reg1_i[SHAMT_W-1:0]; SRA sign-fills from reg2_i[DATA_W-1].
REQ-008 SHALL implement the ARITH class: ADD, ADDU, SUB, SUBU (modulo 2^DATA_W), SLT (signed), SLTU (unsigned), with the SLT/SLTU result 1 or 0.
REQ-009 On ADD/SUB signed overflow SHALL force wreg_o=0 and assert ov_o for that result cycle; ADDU/SUBU never flag.
REQ-010 SHALL implement the MOVE class: MFHI/MFLO return HI/LO, including a value written by an op completing in the same cycle (internal forwarding).
REQ-011 SHALL write HI/LO as follows:
- MTHI/MTLO write reg1_i.
- MULT/MULTU write the signed/unsigned 2*DATA_W-bit product {HI,LO} at the result edge.
REQ-012 SHALL implement DIV/DIVU with a radix-2 restoring FSM with states IDLE, DIV_RUN, DIV_DONE:
- IDLE->DIV_RUN on a valid divide with nonzero divisor.
- DIV_RUN runs exactly DATA_W cycles, then goes to DIV_DONE.
- DIV_DONE writes LO=quotient and HI=remainder, then returns to IDLE.
REQ-013 Signed divide SHALL divide magnitudes, negate the quotient if the operand signs differ, and give the remainder the dividend's sign; MIN/-1 gives quotient MIN, remainder 0.
REQ-014 Divide by zero SHALL NOT enter DIV_RUN; it SHALL complete in one cycle with LO=all-ones and HI=dividend.
REQ-015 stallreq_o SHALL be 1 when (IDLE and a valid nonzero-divisor divide is present) or in DIV_RUN, and 0 in DIV_DONE; total divide latency is DATA_W+2 cycles.
REQ-016 While stallreq_o=1, the output register SHALL emit a bubble (valid_o=0, wreg_o=0, wdata_o=0).
REQ-017 annul_i SHALL take precedence:
- Any state -> IDLE next edge.
- HI/LO unchanged.
- Bubble output.
- stallreq_o low from the next cycle.
REQ-018 valid_i=0 SHALL produce a bubble and no HI/LO update.

Reset
REQ-019 On rst=1 at a clock edge, SHALL set valid_o, wreg_o, ov_o, wd_o, wdata_o, hi_o, lo_o to 0 and the FSM to IDLE.
REQ-020 rst mid-division SHALL abort the divide with no HI/LO update.
REQ-021 stallreq_o SHALL be 0 while rst=1.

Structure
REQ-022 SHALL take EXE_*_OP, EXE_RES_*, and FSM state encodings from the shared define package, with no local literals.
REQ-023 SHALL place the divider datapath and FSM in one sub-module, div_iter (start, signed, annul, dividend, divisor -> busy, done, quotient, remainder).

Verification
REQ-024 SRA, reg2=0x80000010, reg1=4 -> wdata_o=0xF8000001 one cycle later.
REQ-025 ADD 0x7FFFFFFF+1 -> ov_o=1, wreg_o=0; ADDU same operands -> wdata_o=0x80000000, wreg_o=1.
REQ-026 DIV -7/2 -> stallreq_o high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-027 DIVU 5/0 -> no stall, LO=0xFFFFFFFF, HI=5 next cycle.
REQ-028 annul_i pulsed at cycle 10 of a DIV -> FSM IDLE next cycle, HI/LO unchanged, stallreq_o=0.
REQ-029 MULT 0xFFFFFFFF x 2 followed directly by MFHI -> wdata_o=0xFFFFFFFF; rst mid-DIV -> all outputs 0.
